// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional macro MIX_COLUMNS_BYPASS_EN adds in_bypass (columns left unmixed).
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
`ifdef MIX_COLUMNS_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N_STEPS = 4 / COLS_PER_CYCLE;
    localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
            COLS_PER_CYCLE != 4) begin : g_bad_cpc
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [127:0]      work;
    logic [127:0]      work_nxt;
    logic              mode;

`ifdef MIX_COLUMNS_BYPASS_EN
    logic              byp_q;
`else
    localparam logic   byp_q = 1'b0;
`endif

    // GF(2^8) doubling with reduction by 0x11B
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // multiply by a 4-bit constant via an xtime chain
    function automatic logic [7:0] gmul(input logic [7:0] x,
                                        input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? x  : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^
               (k[3] ? x8 : 8'h00);
    endfunction

    // one column; row i uses the coefficient row rotated right by i
    function automatic logic [31:0] mix_col(input logic [31:0] c,
                                            input logic        inv);
        logic [7:0]  s [4];
        logic [3:0]  k [4];
        logic [7:0]  r [4];
        s[0] = c[31:24];
        s[1] = c[23:16];
        s[2] = c[15:8];
        s[3] = c[7:0];
        if (inv) begin
            k[0] = 4'he;
            k[1] = 4'hb;
            k[2] = 4'hd;
            k[3] = 4'h9;
        end else begin
            k[0] = 4'h2;
            k[1] = 4'h3;
            k[2] = 4'h1;
            k[3] = 4'h1;
        end
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                r[i] = r[i] ^ gmul(s[j], k[(j - i + 4) % 4]);
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    // transform the columns selected by the current step
    always_comb begin
        work_nxt = work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            int col;
            col = int'(step) * COLS_PER_CYCLE + k;
            if (!byp_q) begin
                work_nxt[127 - 32*col -: 32] =
                    mix_col(work[127 - 32*col -: 32], mode);
            end
        end
    end

    // control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            work      <= '0;
            mode      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MIX_COLUMNS_BYPASS_EN
            byp_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_state;
                        mode     <= in_inverse;
`ifdef MIX_COLUMNS_BYPASS_EN
                        byp_q    <= in_bypass;
`endif
                        step     <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    work <= work_nxt;
                    if (step == LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_state = work;

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Iterative AES MixColumns / InvMixColumns engine on a full 128-bit state, with the direction selected per block.
- Processes COLS_PER_CYCLE columns per clock, so one datapath trades area against latency.
- Valid/ready handshakes on input and output.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the round datapath; replaces fixed combinational per-column mixing.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- N_STEPS, 4/COLS_PER_CYCLE, derived localparam; compute cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_state/in_inverse valid
- in_ready  output  1  engine can accept a block
- in_state  input  128  AES state, column c at bits [127-32c -: 32], row 0 in the MSB byte of each column
- in_inverse  input  1  0 = MixColumns, 1 = InvMixColumns
- out_valid  output  1  out_state valid
- out_ready  input  1  downstream accepts
- out_state  output  128  result, same layout as in_state
- busy  output  1  block held (any state other than IDLE)

Behaviour:
- Interface timing: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, out_state=0.
  - Any in-flight block is discarded.
  - Reset asserted mid-operation takes priority over every other event on that edge.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_state into the working register, latch in_inverse into the mode register, clear the step counter, and go to CALC.
- CALC:
  - in_ready=0.
  - Each edge transforms columns [step*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1] in place and increments the step counter.
  - After the edge that processes step N_STEPS-1, go to DONE.
  - Counter width is clog2(N_STEPS), minimum 1 bit. The counter does not wrap inside a block.
- DONE:
  - out_valid=1; out_state equals the working register and is stable while out_valid&!out_ready.
  - On out_ready, go to IDLE. out_valid drops the next cycle; out_state retains its value.
- Latency: out_valid is first high in the cycle after the N_STEPS-th edge following the accept edge (CPC=1: 4 edges; CPC=4: 1 edge).
- Throughput: at most one block per N_STEPS+2 cycles. No overlap: in_ready stays low in CALC and DONE, even when out_ready is high.
- Ignored inputs:
  - in_valid while in_ready=0 is ignored. Upstream holds it per handshake rules.
  - Changes on in_inverse/in_state after accept have no effect.
- Arithmetic:
  - GF(2^8) with reduction polynomial 0x11B.
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
  - All multiplies by 02, 03, 09, 0B, 0D, 0E are built from xtime chains with full reduction; plain shifts without reduction are forbidden.
- Forward mix per column s0..s3:
  - r0 = 2s0^3s1^s2^s3
  - r1 = s0^2s1^3s2^s3
  - r2 = s0^s1^2s2^3s3
  - r3 = 3s0^s1^s2^2s3
- Inverse mix per column:
  - r0 = E·s0^B·s1^D·s2^9·s3
  - rows 1–3 rotate the coefficients right by one per row, as in FIPS-197.
- Invariant: forward then inverse on the same state returns the original state.

Optional Feature:
- Macro: MIX_COLUMNS_BYPASS_EN.
- Defined:
  - Adds input port in_bypass (1 bit), latched at accept.
  - When the latched bypass is 1, CALC runs the same N_STEPS cycles but leaves columns unchanged; out_state equals in_state, with identical latency. This serves the final AES round.
- Undefined:
  - No in_bypass port; every block is mixed.

Test Plan:
- CPC=1, forward: in_state=0xdb135345_f20a225c_01010101_2d26314c, in_inverse=0 → out_state=0x8e4da1bc_9fdc589d_01010101_4d7ebdf8; out_valid first high 4 edges after accept.
- CPC=4, inverse: in_state=0x8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inverse=1 → out_state=0xdb135345_f20a225c_01010101_2d26314c; latency 1 edge.
- Reduction check, forward: column d4d4d4d5 → d5d5d7d6; column c6c6c6c6 → c6c6c6c6; 256 random states, forward then inverse → identity for every COLS_PER_CYCLE.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → out_valid=1, out_state constant, in_ready=0, a new in_valid is ignored; raise out_ready → in_ready=1 two cycles later.
- Reset mid-operation: assert rst at step 1 of a CPC=1 block → next edge out_valid=0, out_state=0, in_ready=1; the next block processes correctly.
- MIX_COLUMNS_BYPASS_EN defined, in_bypass=1, in_state=0x0123456789abcdeffedcba9876543210 → out_state identical, latency N_STEPS.
